// File: rtl/demux_1_2_32bit_buf.sv
// 1:2 word steering with a FIFO per destination. A word shows up 1 cycle after acceptance, and a full
// target FIFO stalls only the words bound for it. Optional per-side push counters: `DEMUX_STATS_EN.
module demux_1_2_32bit_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign vld_o   = (count_q != '0);
  assign count_o = count_q;
  assign dat_o   = mem_q[rd_ptr_q];

  // The caller already gates push on !full; the local guards keep the FIFO safe standalone.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && vld_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

module demux_1_2_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             switch,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_b_data,
`ifdef DEMUX_STATS_EN
  output logic [31:0]      stat_a_cnt,
  output logic [31:0]      stat_b_cnt,
`endif
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);
  logic a_full, b_full;
  logic push_a, push_b;

  // Readiness follows only the selected side, so one stalled consumer cannot block the other.
  assign in_ready = switch ? !b_full : !a_full;
  assign push_a   = in_valid && in_ready && !switch;
  assign push_b   = in_valid && in_ready &&  switch;

  demux_1_2_32bit_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_a),
    .push_dat_i (in_data),
    .pop_i      (out_a_ready),
    .vld_o      (out_a_valid),
    .dat_o      (out_a_data),
    .count_o    (a_count),
    .full_o     (a_full)
  );

  demux_1_2_32bit_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_b),
    .push_dat_i (in_data),
    .pop_i      (out_b_ready),
    .vld_o      (out_b_valid),
    .dat_o      (out_b_data),
    .count_o    (b_count),
    .full_o     (b_full)
  );

`ifdef DEMUX_STATS_EN
  logic [31:0] stat_a_q, stat_a_d;
  logic [31:0] stat_b_q, stat_b_d;

  always_comb begin
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    if (push_a) stat_a_d = stat_a_q + 32'd1;
    if (push_b) stat_b_d = stat_b_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
    end
  end

  assign stat_a_cnt = stat_a_q;
  assign stat_b_cnt = stat_b_q;
`endif
endmodule

// File: tb/tb_demux_1_2_32bit_buf.sv
// Random and directed bench for demux_1_2_32bit_buf against a queue-based reference model.
module tb_demux_1_2_32bit_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, switch;
  logic [WIDTH-1:0] in_data;
  logic             out_a_valid, out_a_ready, out_b_valid, out_b_ready;
  logic [WIDTH-1:0] out_a_data, out_b_data;
  logic [CW-1:0]    a_count, b_count;
`ifdef DEMUX_STATS_EN
  logic [31:0]      stat_a_cnt, stat_b_cnt;
  logic [31:0]      m_sa, m_sb;
`endif

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  demux_1_2_32bit_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .switch      (switch),
    .in_data     (in_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_data  (out_a_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .out_b_data  (out_b_data),
`ifdef DEMUX_STATS_EN
    .stat_a_cnt  (stat_a_cnt),
    .stat_b_cnt  (stat_b_cnt),
`endif
    .a_count     (a_count),
    .b_count     (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic model_ready();
    return switch ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
  endfunction

  task automatic check_outputs();
    chk("a_count", 32'(a_count), 32'(qa.size()));
    chk("b_count", 32'(b_count), 32'(qb.size()));
    chk("a_valid", 32'(out_a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(out_b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("a_data", out_a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", out_b_data, qb[0]);
`ifdef DEMUX_STATS_EN
    chk("stat_a", stat_a_cnt, m_sa);
    chk("stat_b", stat_b_cnt, m_sb);
`endif
  endtask

  // Inputs are set at the negedge; the model advances with the DUT on the next rising edge.
  task automatic tick();
    logic rdy;
    #1;
    if (rst_n) chk("in_ready", 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
`ifdef DEMUX_STATS_EN
      m_sa = '0;
      m_sb = '0;
`endif
    end else begin
      rdy = model_ready();
      if (out_a_ready && qa.size() != 0) void'(qa.pop_front());
      if (out_b_ready && qb.size() != 0) void'(qb.pop_front());
      if (in_valid && rdy) begin
        if (switch) qb.push_back(in_data);
        else        qa.push_back(in_data);
`ifdef DEMUX_STATS_EN
        if (switch) m_sb = m_sb + 32'd1;
        else        m_sa = m_sa + 32'd1;
`endif
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic ra, input logic rb);
    in_valid    = v;
    switch      = s;
    in_data     = d;
    out_a_ready = ra;
    out_b_ready = rb;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    @(negedge clk);

    // Reset held for two cycles with a word offered.
    repeat (2) tick();
    chk("rst_a_data", out_a_data, 32'h0);
    chk("rst_b_data", out_b_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0);
    tick();
    chk("first_a_data", out_a_data, 32'hAA);
    chk("first_a_count", 32'(a_count), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();

    // Routing and per-side ordering with both consumers stalled.
    drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h33, 1'b0, 1'b0); tick();
    chk("route_a_count", 32'(a_count), 32'd2);
    chk("route_b_count", 32'(b_count), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("ready_full_a", 32'(in_ready), 32'd0);
    switch = 1'b1; #1;
    chk("ready_b_open", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_a0", out_a_data, 32'h11);
    chk("drain_b0", out_b_data, 32'h33);
    tick();
    chk("drain_a1", out_a_data, 32'h22);
    tick();

    // Full FIFO with a pop: the freed slot is usable only on the next cycle.
    drive(1'b1, 1'b0, 32'h44, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 1'b0, 32'h77, 1'b1, 1'b0); #1;
    chk("full_pop_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_pop_count", 32'(a_count), 32'd1);
    tick();
    chk("full_next_count", 32'(a_count), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();

    // Push and pop together at count 1.
    drive(1'b1, 1'b0, 32'h55, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h66, 1'b1, 1'b0); tick();
    chk("pp_count", 32'(a_count), 32'd1);
    chk("pp_data", out_a_data, 32'h66);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();

    // Streaming ten words through B exercises pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'(i), 1'b0, 1'b1);
      tick();
      chk("stream_b_data", out_b_data, 32'(i));
      chk("stream_b_le1", 32'(b_count <= CW'(1)), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();

    // Random traffic with independent back-pressure on each side.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, $urandom,
            ($urandom % 3) == 0, ($urandom % 2) == 0);
      tick();
    end

    // Mid-operation reset discards buffered words.
    drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_a_count", 32'(a_count), 32'd0);
    chk("mid_rst_b_valid", 32'(out_b_valid), 32'd0);

`ifdef DEMUX_STATS_EN
    chk("stat_a_rst", stat_a_cnt, 32'd0);
    chk("stat_b_rst", stat_b_cnt, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    force dut.stat_a_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_a_q;
    m_sa = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
    tick();
    chk("stat_a_wrap", stat_a_cnt, 32'd0);
`endif

    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_1_2_32bit_buf.md
Name: demux_1_2_32bit_buf

Overview:
- Steering block for the datapath: takes one 32-bit producer stream and routes each word to one of two consumers, selected per word by `switch`.
- Each consumer side has its own small FIFO, so a stalled consumer never corrupts words bound for the other one.
- Uses valid/ready handshakes on all three streams.
- Typical use: write-back/result routing where one source feeds two sinks.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO; must be a power of two, ≥2.
- CW, $clog2(DEPTH+1), width of occupancy count outputs (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- switch  input  1  destination select, sampled with the word: 0 → A, 1 → B.
- in_data  input  WIDTH  producer word.
- out_a_valid  output  1  FIFO A non-empty.
- out_a_ready  input  1  consumer A takes head word.
- out_a_data  output  WIDTH  FIFO A head.
- out_b_valid  output  1  FIFO B non-empty.
- out_b_ready  input  1  consumer B takes head word.
- out_b_data  output  WIDTH  FIFO B head.
- a_count  output  CW  occupancy of FIFO A.
- b_count  output  CW  occupancy of FIFO B.

Behaviour:
- Reset (rst_n=0 at posedge clk): all pointers and counts go to 0, all storage cells clear to 0, no transfers occur. The following outputs hold the values given here from that cycle on:
  - out_a_valid=0, out_b_valid=0, out_a_data=0, out_b_data=0, a_count=0, b_count=0.
  - in_ready=1.
- Reset overrides all push/pop activity in the same cycle. Mid-operation reset discards buffered words.
- in_ready is combinational: switch ? (b_count!=DEPTH) : (a_count!=DEPTH). It depends only on switch and occupancy, never on in_valid.
- Push: in_valid && in_ready writes in_data to the tail of the selected FIFO at the clock edge. No pass-through; the earliest a word appears at an output is the cycle after acceptance (latency 1).
- Pop: out_x_valid && out_x_ready advances the FIFO x head at the clock edge. When out_x_valid=0, out_x_ready is ignored.
- out_x_valid = (x_count != 0). out_x_data is the head cell, registered storage, with no combinational path from in_data.
- Push and pop on the same FIFO in the same cycle (FIFO not full):
  - count unchanged, both pointers advance.
  - this is legal even at count=1: the old head leaves and the new word becomes the head next cycle.
- Full FIFO plus pop in the same cycle: in_ready is still 0 that cycle, so there is no push. The freed slot is available the following cycle.
- A push to one FIFO and a pop from the other in the same cycle are independent.
- A full FIFO A never blocks a word whose switch=1, and vice versa.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts range 0..DEPTH.
- Ordering is preserved within each output. There is no ordering relation between A and B.
- Once out_x_valid=1, it stays 1 until popped. Holding in_valid/in_data/switch stable until in_ready is the producer's responsibility; the block does not check it.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - adds outputs stat_a_cnt [31:0] and stat_b_cnt [31:0].
  - each counts accepted pushes routed to A and B respectively.
  - both reset to 0 under rst_n.
  - increment on the push edge; wrap from 32'hFFFFFFFF to 0.
- Undefined: the ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → every output equals its reset value listed under Behaviour. After release, first push of 32'h0000_00AA with switch=0 → out_a_valid=1, out_a_data=32'hAA the next cycle, a_count=1.
- Routing/order: push 32'h11, 32'h22 (switch=0) and 32'h33 (switch=1), consumers ready=0 → a_count=2, b_count=1. With DEPTH=2, in_ready=0 when switch=0 and 1 when switch=1. Then drain → A yields 11, 22; B yields 33.
- Full + pop: FIFO A full (DEPTH=2), set out_a_ready=1 and in_valid=1 with switch=0 → no push that cycle, a_count=1. Next cycle the push is accepted and a_count stays 1.
- Simultaneous push/pop at count=1: A holds 32'h55; push 32'h66 to A while popping → a_count=1, out_a_data=32'h66 next cycle.
- Wrap: stream 10 words 0..9 into B with out_b_ready=1 continuously → out_b_data sequence 0..9 in order, no loss; b_count never exceeds 1.
- Mid-operation reset and DEMUX_STATS_EN: with both FIFOs partially full, pulse rst_n=0 for 1 cycle → counts 0, valids 0. With the macro defined, stat_a_cnt and stat_b_cnt are 0 after reset; force stat_a_cnt to 32'hFFFFFFFF, push one word to A → stat_a_cnt=0.
